// File: rtl/display_bcd_scan.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | display_bcd_scan: time-multiplexed shift-add-3 seven-segment driver       |
// | Revision: 1.0 - initial release                                           |
// +--------------------------------------------------------------------------+
module display_bcd_scan #(
    parameter int CHANNELS = 4,
    parameter int WIDTH    = 8,
    parameter int DIGITS   = 3
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic                         refresh,
    input  logic                         mode,
    input  logic                         blank_lz,
    input  logic [CHANNELS*WIDTH-1:0]    values,
    output logic [CHANNELS*DIGITS*7-1:0] seg,
    output logic                         busy,
    output logic                         done,
    output logic [CHANNELS-1:0]          ovf
);

    localparam int c_CHW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
    localparam int c_CNW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [c_CHW-1:0] c_CH_LAST  = c_CHW'(CHANNELS - 1);
    localparam logic [c_CNW-1:0] c_CNT_LAST = c_CNW'(WIDTH - 1);

    localparam logic [1:0] c_IDLE  = 2'd0;
    localparam logic [1:0] c_LOAD  = 2'd1;
    localparam logic [1:0] c_SHIFT = 2'd2;
    localparam logic [1:0] c_STORE = 2'd3;

    localparam logic [6:0] c_DASH  = 7'b0111111;
    localparam logic [6:0] c_BLANK = 7'b1111111;

    function automatic logic [63:0] f_pow(input int base, input int n);
        logic [63:0] r;
        r = 64'd1;
        for (int i = 0; i < n; i++) r = r * 64'(base);
        return r;
    endfunction

    localparam logic [63:0] c_DEC_LIM = f_pow(10, DIGITS);
    localparam logic [63:0] c_HEX_LIM = f_pow(16, DIGITS);

    // Patterns are written a..g left to right, then mapped so bit 0 = a.
    function automatic logic [6:0] f_enc(input logic [3:0] nib);
        logic [0:6] p;
        logic [6:0] r;
        case (nib)
            4'h0: p = 7'b0000001;  4'h1: p = 7'b1001111;
            4'h2: p = 7'b0010010;  4'h3: p = 7'b0000110;
            4'h4: p = 7'b1001100;  4'h5: p = 7'b0100100;
            4'h6: p = 7'b0100000;  4'h7: p = 7'b0001111;
            4'h8: p = 7'b0000000;  4'h9: p = 7'b0000100;
            4'hA: p = 7'b0001000;  4'hB: p = 7'b1100000;
            4'hC: p = 7'b0110001;  4'hD: p = 7'b1000010;
            4'hE: p = 7'b0110000;  default: p = 7'b0111000;
        endcase
        for (int k = 0; k < 7; k++) r[k] = p[k];
        return r;
    endfunction

    logic [1:0]                   r_state;
    logic [c_CHW-1:0]             r_ch;
    logic [c_CNW-1:0]             r_cnt;
    logic [CHANNELS*WIDTH-1:0]    r_snap;
    logic                         r_mode;
    logic                         r_blz;
    logic [WIDTH-1:0]             r_bin;
    logic [4*DIGITS-1:0]          r_bcd;
    logic                         r_ovf_cur;
    logic [CHANNELS*DIGITS*7-1:0] r_seg;
    logic [CHANNELS-1:0]          r_ovf;
    logic                         r_busy;
    logic                         r_done;

    logic [WIDTH-1:0]    w_val;
    logic [63:0]         w_val64;
    logic                w_ovf;
    logic [4*DIGITS-1:0] w_adj;
    logic [DIGITS*7-1:0] w_pat;
    logic                w_lead;
    logic [3:0]          w_nib;

    always_comb begin
        w_val = '0;
        for (int i = 0; i < CHANNELS; i++)
            if (r_ch == c_CHW'(i)) w_val = r_snap[i*WIDTH +: WIDTH];
    end

    assign w_val64 = 64'(w_val);
    assign w_ovf   = r_mode ? (w_val64 >= c_HEX_LIM) : (w_val64 >= c_DEC_LIM);

    // Hex mode reuses the same shifter with the add-3 correction disabled.
    always_comb begin
        w_adj = r_bcd;
        if (!r_mode)
            for (int n = 0; n < DIGITS; n++)
                if (r_bcd[n*4 +: 4] >= 4'd5) w_adj[n*4 +: 4] = r_bcd[n*4 +: 4] + 4'd3;
    end

    always_comb begin
        w_pat  = '0;
        w_lead = 1'b1;
        w_nib  = '0;
        for (int d = DIGITS - 1; d >= 0; d--) begin
            w_nib = r_bcd[d*4 +: 4];
            if (r_ovf_cur)
                w_pat[d*7 +: 7] = c_DASH;
            else if (r_blz && w_lead && (w_nib == 4'd0) && (d != 0))
                w_pat[d*7 +: 7] = c_BLANK;
            else
                w_pat[d*7 +: 7] = f_enc(w_nib);
            if (w_nib != 4'd0) w_lead = 1'b0;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            r_state   <= c_IDLE;
            r_ch      <= '0;
            r_cnt     <= '0;
            r_snap    <= '0;
            r_mode    <= 1'b0;
            r_blz     <= 1'b0;
            r_bin     <= '0;
            r_bcd     <= '0;
            r_ovf_cur <= 1'b0;
            r_seg     <= '1;
            r_ovf     <= '0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                c_IDLE: begin
                    if (refresh) begin
                        r_snap  <= values;
                        r_mode  <= mode;
                        r_blz   <= blank_lz;
                        r_ch    <= '0;
                        r_busy  <= 1'b1;
                        r_state <= c_LOAD;
                    end
                end
                c_LOAD: begin
                    r_bin     <= w_val;
                    r_bcd     <= '0;
                    r_ovf_cur <= w_ovf;
                    r_cnt     <= '0;
                    r_state   <= c_SHIFT;
                end
                c_SHIFT: begin
                    {r_bcd, r_bin} <= {w_adj, r_bin} << 1;
                    r_cnt          <= r_cnt + 1'b1;
                    if (r_cnt == c_CNT_LAST) r_state <= c_STORE;
                end
                c_STORE: begin
                    for (int i = 0; i < CHANNELS; i++)
                        if (r_ch == c_CHW'(i)) begin
                            r_seg[i*DIGITS*7 +: DIGITS*7] <= w_pat;
                            r_ovf[i]                      <= r_ovf_cur;
                        end
                    if (r_ch == c_CH_LAST) begin
                        r_ch    <= '0;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_state <= c_IDLE;
                    end else begin
                        r_ch    <= r_ch + 1'b1;
                        r_state <= c_LOAD;
                    end
                end
                default: r_state <= c_IDLE;
            endcase
        end
    end

    assign seg  = r_seg;
    assign busy = r_busy;
    assign done = r_done;
    assign ovf  = r_ovf;

endmodule
`default_nettype wire

// File: doc/display_bcd_scan.md
# display_bcd_scan

Sequential multi-channel binary-to-seven-segment display driver for the board top level of the MIPS processor. It replaces per-digit combinational divide/modulo logic with one shared shift-add-3 (double-dabble) converter that is time-multiplexed across CHANNELS input words. It supports decimal and hexadecimal modes, leading-zero blanking and overflow indication. Each channel drives DIGITS active-low seven-segment digits, bit 0 = segment a.

## Interface
- CHANNELS, 4, number of independent values displayed (1..8)
- WIDTH, 8, bits per value (1..32)
- DIGITS, 3, seven-segment digits per channel (1..10)

- clock  input  1  single clock; all state changes on rising edge
- reset  input  1  synchronous, active-low; sampled on rising edge of clock
- refresh  input  1  start a conversion scan; accepted only when busy=0
- mode  input  1  0 = decimal, 1 = hexadecimal; sampled at accept
- blank_lz  input  1  1 = blank leading zero digits; sampled at accept
- values  input  CHANNELS*WIDTH  channel ch = values[ch*WIDTH +: WIDTH]; all snapshotted at accept
- seg  output  CHANNELS*DIGITS*7  digit d (0 = least significant) of channel ch = seg[(ch*DIGITS+d)*7 +: 7]; offset +0 = a ... +6 = g; active-low
- busy  output  1  high while a scan is in progress
- done  output  1  one-cycle pulse when the last channel is stored
- ovf  output  CHANNELS  per-channel overflow flag from the latest scan

## Operation
- States: IDLE, LOAD, SHIFT, STORE. Channel index ch, shift counter 0..WIDTH-1.
- IDLE: refresh=1 -> snapshot values/mode/blank_lz, ch=0, busy=1, go LOAD.
- LOAD (1 cycle): load snapshot[ch] into shift register, clear BCD register (4*DIGITS bits), compute overflow: decimal value >= 10^DIGITS; hex value >= 16^DIGITS (never when WIDTH <= 4*DIGITS).
- SHIFT (WIDTH cycles): decimal: every BCD nibble >= 5 gets +3, then {bcd, bin} shifts left by 1. Hex: plain left shift of the binary into the nibble register. Both modes take exactly WIDTH cycles; the result is the nibbles of the value, zero-extended.
- STORE (1 cycle): write DIGITS encoded patterns for channel ch and ovf[ch]. Then ch<CHANNELS-1 -> ch+1, LOAD; else -> IDLE, done=1, busy=0.
- Encoding (a..g, active-low): 0=0000001, 1=1001111, 2=0010010, 3=0000110, 4=1001100, 5=0100100, 6=0100000, 7=0001111, 8=0000000, 9=0000100, A=0001000, b=1100000, C=0110001, d=1000010, E=0110000, F=0111000; dash=1111110; blank=1111111.
- Leading-zero blanking: with blank_lz=1, each zero digit above the most-significant nonzero digit shows blank. Digit 0 always shows, so value 0 shows "0".
- Overflow: every digit of the channel shows dash; blanking is ignored; ovf[ch]=1.
- Channels not yet stored in the current scan hold their previous seg and ovf.
- refresh while busy=1: ignored, no queuing. Input changes after accept do not affect the scan.

## Timing
- Reset (reset=0 at an edge): state IDLE, seg all 1111111, busy=0, done=0, ovf=0, ch=0. This applies mid-scan: the scan is aborted and displays are blanked.
- Accept edge E0 (IDLE, refresh=1): busy=1 from E0.
- Per-channel latency is WIDTH+2 cycles. Channel ch seg/ovf update at edge E0+(ch+1)*(WIDTH+2).
- The last store occurs at E0+CHANNELS*(WIDTH+2). At that same edge done=1 for one cycle and busy=0. A refresh during that done cycle is accepted at the next edge, so back-to-back scans have a one-cycle gap.
- The default scan takes 40 cycles.

## Test plan
- Reset, then decimal, blank_lz=0, values ch0..3 = 255,0,9,100, refresh -> at +40 cycles done pulse; ch0 digits (d2..d0) 2,5,5 = 0010010,0100100,0100100; ch1 0,0,0; ch2 0,0,9; ch3 1,0,0; ovf=0000.
- Decimal, blank_lz=1, ch0=7, ch1=0, ch2=40 -> ch0 blank,blank,0001111; ch1 blank,blank,0000001; ch2 blank,1001100,0000001.
- Hex, blank_lz=1, ch0=0xAB -> blank,0001000,1100000. Same with blank_lz=0 -> 0000001,0001000,1100000.
- DIGITS=2, decimal, ch0=100, ch1=99 -> ch0 both digits 1111110 with ovf[0]=1; ch1 9,9 with ovf[1]=0. Hex mode with ch0=0xFF -> "FF", no overflow.
- Pulse refresh at E0, pulse again at E0+5, and change values at E0+3 -> only one done pulse at E0+40; displayed data is the E0 snapshot. The ch1 display is unchanged before E0+20.
- Drive reset=0 at E0+15 -> next edge all seg 1111111, busy=0, ovf=0, no done pulse. A refresh after reset completes a normal scan.
